// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle signed multiply/divide responder for the
// multicycle MIPS datapath. One iteration per clock over WIDTH cycles,
// a sign-fixup cycle, then a one-cycle done pulse with HI/LO and div0.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             MDCtrl,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               isDiv_q;
  logic               signA_q;
  logic               signB_q;
  logic [WIDTH-1:0]   magA_q;
  logic [WIDTH-1:0]   magB_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               busy_q;
  logic               done_q;
  logic               div0_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [WIDTH:0]     multSum;
  logic [WIDTH:0]     divShift;
  logic [WIDTH:0]     divDiff;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix;
  logic [WIDTH-1:0]   remFix;

  // Magnitudes of the incoming operands; the most-negative value maps to
  // 2^(WIDTH-1), which is exact when read back as unsigned.
  always_comb begin
    absA = opA;
    absB = opB;
    if (opA[WIDTH-1]) absA = -opA;
    if (opB[WIDTH-1]) absB = -opB;
  end

  // One unsigned iteration. Mult keeps {partial upper, remaining multiplier}
  // in acc and shifts right; div keeps {remainder, dividend/quotient} and
  // shifts left, restoring when the trial subtraction borrows.
  always_comb begin
    multSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, magA_q} : '0);
    divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    divDiff  = divShift - {1'b0, magB_q};
    acc_d    = {multSum, acc_q[WIDTH-1:1]};
    if (isDiv_q) begin
      if (divDiff[WIDTH]) begin
        acc_d = {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_d = {divDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
    end
  end

  // Sign fixup: product and quotient negate on differing signs (quotient
  // truncates toward zero), remainder follows the dividend's sign.
  always_comb begin
    prodFix = acc_q;
    quoFix  = acc_q[WIDTH-1:0];
    remFix  = acc_q[2*WIDTH-1:WIDTH];
    if (signA_q ^ signB_q) begin
      prodFix = -acc_q;
      quoFix  = -acc_q[WIDTH-1:0];
    end
    if (signA_q) remFix = -acc_q[2*WIDTH-1:WIDTH];
  end

  // Control FSM with registered outputs; reset discards any in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      isDiv_q <= 1'b0;
      signA_q <= 1'b0;
      signB_q <= 1'b0;
      magA_q  <= '0;
      magB_q  <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            isDiv_q <= MDCtrl;
            signA_q <= opA[WIDTH-1];
            signB_q <= opB[WIDTH-1];
            magA_q  <= absA;
            magB_q  <= absB;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            div0_q  <= 1'b0;
            if (MDCtrl && (opB == '0)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              div0_q  <= 1'b1;
            end else begin
              state_q <= CALC;
              acc_q   <= MDCtrl ? {{WIDTH{1'b0}}, absA} : {{WIDTH{1'b0}}, absB};
            end
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) state_q <= FIX;
        end
        FIX: begin
          if (isDiv_q) begin
            hi_q <= remFix;
            lo_q <= quoFix;
          end else begin
            hi_q <= prodFix[2*WIDTH-1:WIDTH];
            lo_q <= prodFix[WIDTH-1:0];
          end
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign div0 = div0_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: self-checking bench for mult_div_unit with a 64-bit
// integer arithmetic reference model.
module tb_mult_div_unit;

  localparam int WIDTH      = 32;
  localparam int LAT_NORMAL = WIDTH + 2;
  localparam int LAT_DIV0   = 1;
  localparam int TIMEOUT    = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        MDCtrl;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div0;

  int checks = 0;
  int errors = 0;

  logic [31:0] expHi   = '0;
  logic [31:0] expLo   = '0;
  logic        expDiv0 = 1'b0;

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .MDCtrl(MDCtrl),
    .opA   (opA),
    .opB   (opB),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .div0  (div0)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Reference model: signed arithmetic on 64-bit integers. A zero divisor
  // leaves the previous HI/LO untouched and raises div0.
  task automatic modelOp(input logic md, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint p;
    longint q;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!md) begin
      p       = sa * sb;
      expHi   = p[63:32];
      expLo   = p[31:0];
      expDiv0 = 1'b0;
    end else if (b == 32'h0) begin
      expDiv0 = 1'b1;
    end else begin
      q       = sa / sb;
      r       = sa % sb;
      expHi   = r[31:0];
      expLo   = q[31:0];
      expDiv0 = 1'b0;
    end
  endtask

  function automatic logic [31:0] corner();
    case ($urandom_range(4))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return 32'h7FFF_FFFF;
    endcase
  endfunction

  // Issues one start (caller sits just after a clock edge), waits for done
  // and returns the observed results, latency from the start cycle, and
  // whether busy/done behaved around the operation.
  task automatic applyStimulus(input logic md, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] obsHi, output logic [31:0] obsLo,
                               output logic obsDiv0, output int lat,
                               output logic busyOk, output logic timedOut);
    busyOk   = 1'b1;
    timedOut = 1'b0;
    if (busy !== 1'b0) busyOk = 1'b0;
    start  = 1'b1;
    MDCtrl = md;
    opA    = a;
    opB    = b;
    lat    = 0;
    @(posedge clk); #1;
    lat    = 1;
    start  = 1'b0;
    MDCtrl = 1'($urandom_range(1));
    opA    = $urandom;
    opB    = $urandom;
    while (done !== 1'b1 && !timedOut) begin
      if (busy !== 1'b1) busyOk = 1'b0;
      if (lat >= TIMEOUT) timedOut = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    obsHi   = hi;
    obsLo   = lo;
    obsDiv0 = div0;
    if (!timedOut) begin
      if (busy !== 1'b1) busyOk = 1'b0;
      @(posedge clk); #1;
      if (busy !== 1'b0 || done !== 1'b0) busyOk = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start  = 1'b1;
    MDCtrl = 1'b1;
    opA    = 32'h5;
    opB    = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected 00000000", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected 00000000", lo); end
    checks++; if (div0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_div0: got %b expected 0", div0); end
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_mult_directed();
    logic [31:0] va[3]  = '{32'h0000_0007, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [31:0] vb[3]  = '{32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [31:0] vhi[3] = '{32'hFFFF_FFFF, 32'h3FFF_FFFF, 32'h4000_0000};
    logic [31:0] vlo[3] = '{32'hFFFF_FFEB, 32'h0000_0001, 32'h0000_0000};
    logic [31:0] oHi, oLo;
    logic oD0, bOk, tOut;
    int lat;
    for (int i = 0; i < 3; i++) begin
      modelOp(1'b0, va[i], vb[i]);
      applyStimulus(1'b0, va[i], vb[i], oHi, oLo, oD0, lat, bOk, tOut);
      checks++; if (lat !== LAT_NORMAL) begin errors++; $display("[TB] FAIL mult_latency[%0d]: got %0d expected %0d", i, lat, LAT_NORMAL); end
      checks++; if (oHi !== vhi[i]) begin errors++; $display("[TB] FAIL mult_hi[%0d]: got %h expected %h", i, oHi, vhi[i]); end
      checks++; if (oLo !== vlo[i]) begin errors++; $display("[TB] FAIL mult_lo[%0d]: got %h expected %h", i, oLo, vlo[i]); end
      checks++; if (oD0 !== 1'b0) begin errors++; $display("[TB] FAIL mult_div0[%0d]: got %b expected 0", i, oD0); end
      checks++; if (bOk !== 1'b1) begin errors++; $display("[TB] FAIL mult_busy[%0d]: got %b expected 1", i, bOk); end
    end
  endtask

  task automatic test_div_directed();
    logic [31:0] va[3]  = '{32'hFFFF_FFF9, 32'h0000_0007, 32'h8000_0000};
    logic [31:0] vb[3]  = '{32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] vhi[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    logic [31:0] vlo[3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000};
    logic [31:0] oHi, oLo;
    logic oD0, bOk, tOut;
    int lat;
    for (int i = 0; i < 3; i++) begin
      modelOp(1'b1, va[i], vb[i]);
      applyStimulus(1'b1, va[i], vb[i], oHi, oLo, oD0, lat, bOk, tOut);
      checks++; if (lat !== LAT_NORMAL) begin errors++; $display("[TB] FAIL div_latency[%0d]: got %0d expected %0d", i, lat, LAT_NORMAL); end
      checks++; if (oHi !== vhi[i]) begin errors++; $display("[TB] FAIL div_hi[%0d]: got %h expected %h", i, oHi, vhi[i]); end
      checks++; if (oLo !== vlo[i]) begin errors++; $display("[TB] FAIL div_lo[%0d]: got %h expected %h", i, oLo, vlo[i]); end
      checks++; if (oD0 !== 1'b0) begin errors++; $display("[TB] FAIL div_div0[%0d]: got %b expected 0", i, oD0); end
      checks++; if (bOk !== 1'b1) begin errors++; $display("[TB] FAIL div_busy[%0d]: got %b expected 1", i, bOk); end
    end
  endtask

  task automatic test_div0();
    logic [31:0] oHi, oLo;
    logic oD0, bOk, tOut;
    int lat;
    modelOp(1'b1, 32'd7, 32'd2);
    applyStimulus(1'b1, 32'd7, 32'd2, oHi, oLo, oD0, lat, bOk, tOut);
    checks++; if (oHi !== 32'h1 || oLo !== 32'h3) begin errors++; $display("[TB] FAIL div0_prior: got %h/%h expected 00000001/00000003", oHi, oLo); end
    modelOp(1'b1, 32'd5, 32'd0);
    applyStimulus(1'b1, 32'd5, 32'd0, oHi, oLo, oD0, lat, bOk, tOut);
    checks++; if (lat !== LAT_DIV0) begin errors++; $display("[TB] FAIL div0_latency: got %0d expected %0d", lat, LAT_DIV0); end
    checks++; if (oD0 !== 1'b1) begin errors++; $display("[TB] FAIL div0_flag: got %b expected 1", oD0); end
    checks++; if (oHi !== 32'h1) begin errors++; $display("[TB] FAIL div0_hi_held: got %h expected 00000001", oHi); end
    checks++; if (oLo !== 32'h3) begin errors++; $display("[TB] FAIL div0_lo_held: got %h expected 00000003", oLo); end
    checks++; if (bOk !== 1'b1) begin errors++; $display("[TB] FAIL div0_busy: got %b expected 1", bOk); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (div0 !== 1'b1) begin errors++; $display("[TB] FAIL div0_level[%0d]: got %b expected 1", i, div0); end
    end
    // A fresh valid start clears div0 right after acceptance.
    modelOp(1'b0, 32'h1234_5678, 32'hFFFF_FFFB);
    start  = 1'b1;
    MDCtrl = 1'b0;
    opA    = 32'h1234_5678;
    opB    = 32'hFFFF_FFFB;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    checks++; if (div0 !== 1'b0) begin errors++; $display("[TB] FAIL div0_clear: got %b expected 0", div0); end
    while (done !== 1'b1 && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== LAT_NORMAL) begin errors++; $display("[TB] FAIL div0_next_latency: got %0d expected %0d", lat, LAT_NORMAL); end
    checks++; if (hi !== expHi || lo !== expLo) begin errors++; $display("[TB] FAIL div0_next_result: got %h/%h expected %h/%h", hi, lo, expHi, expLo); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_while_busy();
    int lat;
    modelOp(1'b0, 32'd7, 32'hFFFF_FFFD);
    start  = 1'b1;
    MDCtrl = 1'b0;
    opA    = 32'd7;
    opB    = 32'hFFFF_FFFD;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    while (lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    start  = 1'b1;
    MDCtrl = 1'b1;
    opA    = 32'hFFFF_FFF9;
    opB    = 32'h0;
    @(posedge clk); #1;
    lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== LAT_NORMAL) begin errors++; $display("[TB] FAIL busy_start_latency: got %0d expected %0d", lat, LAT_NORMAL); end
    checks++; if (hi !== expHi) begin errors++; $display("[TB] FAIL busy_start_hi: got %h expected %h", hi, expHi); end
    checks++; if (lo !== expLo) begin errors++; $display("[TB] FAIL busy_start_lo: got %h expected %h", lo, expLo); end
    checks++; if (div0 !== 1'b0) begin errors++; $display("[TB] FAIL busy_start_div0: got %b expected 0", div0); end
    // Start raised during the DONE cycle must be dropped.
    start  = 1'b1;
    MDCtrl = 1'b1;
    opA    = 32'd5;
    opB    = 32'h0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || div0 !== 1'b0) begin errors++; $display("[TB] FAIL done_cycle_start: got busy=%b done=%b div0=%b expected 0/0/0", busy, done, div0); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] oHi, oLo;
    logic oD0, bOk, tOut;
    logic sawDone;
    int lat;
    start  = 1'b1;
    MDCtrl = 1'b0;
    opA    = 32'h0BAD_F00D;
    opB    = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    while (lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset   = 1'b0;
    expHi   = '0;
    expLo   = '0;
    expDiv0 = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ctrl: got busy=%b done=%b expected 0/0", busy, done); end
    checks++; if (hi !== expHi || lo !== expLo) begin errors++; $display("[TB] FAIL midreset_hilo: got %h/%h expected %h/%h", hi, lo, expHi, expLo); end
    checks++; if (div0 !== expDiv0) begin errors++; $display("[TB] FAIL midreset_div0: got %b expected %b", div0, expDiv0); end
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) sawDone = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (sawDone !== 1'b0) begin errors++; $display("[TB] FAIL midreset_no_done: got %b expected 0", sawDone); end
    modelOp(1'b1, 32'h8000_0001, 32'h0000_0003);
    applyStimulus(1'b1, 32'h8000_0001, 32'h0000_0003, oHi, oLo, oD0, lat, bOk, tOut);
    checks++; if (lat !== LAT_NORMAL) begin errors++; $display("[TB] FAIL postreset_latency: got %0d expected %0d", lat, LAT_NORMAL); end
    checks++; if (oHi !== expHi || oLo !== expLo) begin errors++; $display("[TB] FAIL postreset_result: got %h/%h expected %h/%h", oHi, oLo, expHi, expLo); end
  endtask

  task automatic test_random_back_to_back();
    logic [31:0] a, b, oHi, oLo;
    logic md, oD0, bOk, tOut;
    int lat, expLat;
    for (int i = 0; i < 24; i++) begin
      md = 1'($urandom_range(1));
      a  = ($urandom_range(3) == 0) ? corner() : $urandom;
      b  = ($urandom_range(3) == 0) ? corner() : $urandom;
      if (md && $urandom_range(7) == 0) b = 32'h0;
      expLat = (md && b == 32'h0) ? LAT_DIV0 : LAT_NORMAL;
      modelOp(md, a, b);
      applyStimulus(md, a, b, oHi, oLo, oD0, lat, bOk, tOut);
      checks++; if (lat !== expLat) begin errors++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, expLat); end
      checks++; if (oHi !== expHi) begin errors++; $display("[TB] FAIL rand_hi[%0d] md=%b a=%h b=%h: got %h expected %h", i, md, a, b, oHi, expHi); end
      checks++; if (oLo !== expLo) begin errors++; $display("[TB] FAIL rand_lo[%0d] md=%b a=%h b=%h: got %h expected %h", i, md, a, b, oLo, expLo); end
      checks++; if (oD0 !== expDiv0) begin errors++; $display("[TB] FAIL rand_div0[%0d]: got %b expected %b", i, oD0, expDiv0); end
      checks++; if (bOk !== 1'b1) begin errors++; $display("[TB] FAIL rand_busy[%0d]: got %b expected 1", i, bOk); end
    end
  endtask

  // Scenario sequence; each task leaves the bench just after a clock edge.
  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    MDCtrl = 1'b0;
    opA    = '0;
    opB    = '0;
    $display("[TB] mult_div_unit bench start");
    test_reset();
    test_mult_directed();
    test_div_directed();
    test_div0();
    test_start_while_busy();
    test_reset_mid_op();
    test_random_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
